// File: rtl/ram_arb_pkg.sv
// Shared types for ram_port_arbiter: default RAM geometry, requester id and read-return tag.
package ram_arb_pkg;
    localparam int RAM_ADDR_W  = 12;
    localparam int RAM_DATA_W  = 64;
    localparam int NUM_REQ_MAX = 8;
    // Sized for the largest supported requester count so one type serves every build.
    localparam int ID_W        = $clog2(NUM_REQ_MAX);

    typedef logic [ID_W-1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_tag_t;

    function automatic req_id_t next_id(input req_id_t id, input int n);
        return req_id_t'((int'(id) + 1) % n);
    endfunction
endpackage

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot grant to the first requester at or after ptr (wrapping).
// A fixed-priority arbiter is obtained by tying ptr to zero.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  req_id_t            ptr,
    output logic [NUM_REQ-1:0] gnt,
    output req_id_t            gnt_id,
    output logic               any
);
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!any && req[i] && ((int'(ptr) + k) % NUM_REQ) == i) begin
                    any    = 1'b1;
                    gnt[i] = 1'b1;
                    gnt_id = req_id_t'(i);
                end
            end
        end
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares ram_4096 between NUM_REQ requesters, independent write/read arbitration.
// Define RAM_ARB_FIXED_PRI_EN for lowest-index-wins priority on both ports instead of round-robin.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = RAM_ADDR_W,
    parameter int DATA_W  = RAM_DATA_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        wr_req,
    input  logic [NUM_REQ*ADDR_W-1:0] wr_addr,
    input  logic [NUM_REQ*DATA_W-1:0] wr_data,
    output logic [NUM_REQ-1:0]        wr_gnt,
    input  logic [NUM_REQ-1:0]        rd_req,
    input  logic [NUM_REQ*ADDR_W-1:0] rd_addr,
    output logic [NUM_REQ-1:0]        rd_gnt,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      ram_write,
    output logic [ADDR_W-1:0]         ram_wr_address,
    output logic [DATA_W-1:0]         ram_data_in,
    output logic                      ram_read,
    output logic [ADDR_W-1:0]         ram_rd_address,
    input  logic [DATA_W-1:0]         ram_data_out
);
    req_id_t              wr_ptr, rd_ptr, wr_id, rd_id;
    logic [NUM_REQ-1:0]   wr_gnt_raw, rd_gnt_raw, rd_cand;
    logic                 wr_any, rd_any;
    logic [ADDR_W-1:0]    wr_addr_sel, rd_addr_sel;
    logic                 write_q, read_q;
    rd_tag_t              rd_tag_pipe [1:2];

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
        .req(wr_req), .ptr(wr_ptr), .gnt(wr_gnt_raw), .gnt_id(wr_id), .any(wr_any)
    );

    assign wr_addr_sel = wr_addr[int'(wr_id)*ADDR_W +: ADDR_W];

    // A read to the address being written this cycle waits one cycle so it sees the new data.
    always_comb begin
        rd_cand = rd_req;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wr_any && rd_addr[i*ADDR_W +: ADDR_W] == wr_addr_sel)
                rd_cand[i] = 1'b0;
        end
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
        .req(rd_cand), .ptr(rd_ptr), .gnt(rd_gnt_raw), .gnt_id(rd_id), .any(rd_any)
    );

    assign rd_addr_sel = rd_addr[int'(rd_id)*ADDR_W +: ADDR_W];
    assign wr_gnt      = reset ? '0 : wr_gnt_raw;
    assign rd_gnt      = reset ? '0 : rd_gnt_raw;

`ifdef RAM_ARB_FIXED_PRI_EN
    assign wr_ptr = '0;
    assign rd_ptr = '0;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_any) wr_ptr <= next_id(wr_id, NUM_REQ);
            if (rd_any) rd_ptr <= next_id(rd_id, NUM_REQ);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            write_q        <= 1'b0;
            read_q         <= 1'b0;
            ram_wr_address <= '0;
            ram_data_in    <= '0;
            ram_rd_address <= '0;
            rd_tag_pipe[1] <= '0;
            rd_tag_pipe[2] <= '0;
        end else begin
            write_q        <= wr_any;
            read_q         <= rd_any;
            if (wr_any) begin
                ram_wr_address <= wr_addr_sel;
                ram_data_in    <= wr_data[int'(wr_id)*DATA_W +: DATA_W];
            end
            if (rd_any) ram_rd_address <= rd_addr_sel;
            rd_tag_pipe[1] <= '{valid: rd_any, id: rd_id};
            rd_tag_pipe[2] <= rd_tag_pipe[1];
        end
    end

    // Reset also suppresses an access already staged in the RAM-side registers.
    assign ram_write = write_q & ~reset;
    assign ram_read  = read_q & ~reset;

    always_comb begin
        rd_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rd_tag_pipe[2].valid && !reset && rd_tag_pipe[2].id == req_id_t'(i))
                rd_valid[i] = 1'b1;
        end
    end

    assign rd_data = (rd_tag_pipe[2].valid && !reset) ? ram_data_out : '0;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, request-level reference model and read-return scoreboard.
module tb_ram_port_arbiter;
    localparam int N  = 2;
    localparam int AW = 12;
    localparam int DW = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      wr_req = '0, rd_req = '0;
    logic [N*AW-1:0]   wr_addr = '0, rd_addr = '0;
    logic [N*DW-1:0]   wr_data = '0;
    logic [N-1:0]      wr_gnt, rd_gnt, rd_valid;
    logic [DW-1:0]     rd_data, ram_data_in, ram_data_out;
    logic              ram_write, ram_read;
    logic [AW-1:0]     ram_wr_address, ram_rd_address;

    ram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .ram_write(ram_write), .ram_wr_address(ram_wr_address), .ram_data_in(ram_data_in),
        .ram_read(ram_read), .ram_rd_address(ram_rd_address), .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int a);
        return {32'(a) * 32'h9E3779B9, 32'(a) ^ 32'h5A5A0000};
    endfunction

    // Behavioural ram_4096: synchronous write, registered read.
    logic [DW-1:0] mem [4096];
    bit            written [4096];
    always @(posedge clk) begin
        if (ram_write) begin
            mem[ram_wr_address]     <= ram_data_in;
            written[ram_wr_address] <= 1'b1;
        end
        if (ram_read)
            ram_data_out <= written[ram_rd_address] ? mem[ram_rd_address] : init_val(int'(ram_rd_address));
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0, checks = 0;
    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Requester-side state: each pending request is held until its grant.
    bit            w_pend [N], r_pend [N];
    logic [AW-1:0] w_a [N], r_a [N];
    logic [DW-1:0] w_d [N];

    // Reference model state.
    logic [DW-1:0] ref_mem [int];
    int            m_wp = 0, m_rp = 0;
    bit            pw_v = 0;
    logic [AW-1:0] pw_a;
    logic [DW-1:0] pw_d;
    logic [N-1:0]  obs_wg, obs_rg;

    typedef struct { int id; logic [DW-1:0] data; int cyc; } exp_t;
    exp_t q [$];

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(int'(a));
    endfunction

    // First pending requester counting up from ptr, wrapping; -1 if none.
    function automatic int pick(input bit [N-1:0] cand, input int ptr);
        for (int k = 0; k < N; k++) begin
            int i = (ptr + k) % N;
            if (cand[i]) return i;
        end
        return -1;
    endfunction

    task automatic step(input bit rst);
        int wi, ri;
        bit [N-1:0] wc, rc;
        logic [N-1:0] ewg, erg;
        @(negedge clk);
        reset = rst;
        for (int i = 0; i < N; i++) begin
            wr_req[i] = w_pend[i];
            rd_req[i] = r_pend[i];
            wr_addr[i*AW +: AW] = w_a[i];
            rd_addr[i*AW +: AW] = r_a[i];
            wr_data[i*DW +: DW] = w_d[i];
        end
        #1;
        obs_wg = wr_gnt;
        obs_rg = rd_gnt;
        if (rst) begin
            chk("rst_wr_gnt", wr_gnt, '0);
            chk("rst_rd_gnt", rd_gnt, '0);
            q.delete();
            m_wp = 0; m_rp = 0; pw_v = 0;
            return;
        end
        // A write granted last cycle lands in the RAM before any read granted now samples it.
        if (pw_v) begin ref_mem[int'(pw_a)] = pw_d; pw_v = 0; end
        for (int i = 0; i < N; i++) wc[i] = w_pend[i];
        wi = pick(wc, m_wp);
        for (int i = 0; i < N; i++) rc[i] = r_pend[i] && !(wi >= 0 && r_a[i] == w_a[wi]);
        ri = pick(rc, m_rp);
        ewg = '0; erg = '0;
        if (wi >= 0) ewg[wi] = 1'b1;
        if (ri >= 0) erg[ri] = 1'b1;
        chk("wr_gnt", wr_gnt, ewg);
        chk("rd_gnt", rd_gnt, erg);
        if (ri >= 0) begin
            q.push_back('{id: ri, data: ref_rd(r_a[ri]), cyc: cyc + 2});
            r_pend[ri] = 0;
`ifndef RAM_ARB_FIXED_PRI_EN
            m_rp = (ri + 1) % N;
`endif
        end
        if (wi >= 0) begin
            pw_v = 1; pw_a = w_a[wi]; pw_d = w_d[wi];
            w_pend[wi] = 0;
`ifndef RAM_ARB_FIXED_PRI_EN
            m_wp = (wi + 1) % N;
`endif
        end
    endtask

    // Scoreboard monitor: every returned read is matched against the oldest expectation.
    initial begin
        exp_t e;
        logic [N-1:0] ev;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                ev = '0;
                ev[e.id] = 1'b1;
                chk("rd_valid", rd_valid, ev);
                chk("rd_data", rd_data, e.data);
            end else if (rd_valid !== '0) begin
                chk("rd_valid_unexpected", rd_valid, '0);
            end
        end
    end

    initial begin
        logic [N-1:0] t3_exp;
        for (int i = 0; i < N; i++) begin
            w_pend[i] = 0; r_pend[i] = 0; w_a[i] = '0; r_a[i] = '0; w_d[i] = '0;
        end

        // 1: reset with every request raised
        for (int i = 0; i < N; i++) begin
            w_pend[i] = 1; r_pend[i] = 1; w_a[i] = AW'(i); r_a[i] = AW'(8 + i); w_d[i] = 64'hDEAD;
        end
        repeat (3) begin
            step(1);
            chk("rst_ram_write", ram_write, '0);
            chk("rst_ram_read", ram_read, '0);
            chk("rst_rd_valid", rd_valid, '0);
            chk("rst_rd_data", rd_data, '0);
        end
        for (int i = 0; i < N; i++) begin w_pend[i] = 0; r_pend[i] = 0; end

        // 3: both writers held for four cycles
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < N; i++) begin
                w_pend[i] = 1; w_a[i] = AW'(12'h300 + i); w_d[i] = 64'(k * 16 + i);
            end
            step(0);
`ifdef RAM_ARB_FIXED_PRI_EN
            t3_exp = 2'b01;
`else
            t3_exp = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
            chk("t3_wr_gnt_seq", obs_wg, t3_exp);
        end
        for (int i = 0; i < N; i++) w_pend[i] = 0;

        // 2: write by 0 then read by 1 of the same location
        w_pend[0] = 1; w_a[0] = 12'h010; w_d[0] = 64'hA5A5;
        step(0);
        r_pend[1] = 1; r_a[1] = 12'h010;
        step(0);
        chk("t2_rd_gnt", obs_rg, 2'b10);
        step(0);
        step(0);
        chk("t2_rd_valid", rd_valid, 2'b10);
        chk("t2_rd_data", rd_data, 64'hA5A5);

        // 4: same-cycle write/read to one address
        w_pend[0] = 1; w_a[0] = 12'h123; w_d[0] = 64'h55;
        r_pend[1] = 1; r_a[1] = 12'h123;
        step(0);
        chk("t4_wr_gnt", obs_wg, 2'b01);
        chk("t4_rd_blocked", obs_rg, 2'b00);
        step(0);
        chk("t4_rd_gnt_next", obs_rg, 2'b10);
        step(0);
        step(0);
        chk("t4_rd_data", rd_data, 64'h55);

        // 5: back-to-back reads from both requesters
        r_pend[0] = 1; r_a[0] = 12'h001;
        r_pend[1] = 1; r_a[1] = 12'h002;
        step(0);
        chk("t5_rd_gnt0", obs_rg, 2'b01);
        step(0);
        chk("t5_rd_gnt1", obs_rg, 2'b10);
        step(0);
        chk("t5_rd_valid0", rd_valid, 2'b01);
        chk("t5_rd_data0", rd_data, init_val(1));
        step(0);
        chk("t5_rd_valid1", rd_valid, 2'b10);
        chk("t5_rd_data1", rd_data, init_val(2));

        // 6: reset one cycle after a read grant
        w_pend[0] = 1; w_a[0] = 12'h200; w_d[0] = 64'h77;
        r_pend[0] = 1; r_a[0] = 12'h201;
        step(0);
        step(1);
        for (int i = 0; i < N; i++) begin
            w_pend[i] = 1; w_a[i] = AW'(12'h400 + i); w_d[i] = 64'(i + 9);
            r_pend[i] = 1; r_a[i] = AW'(12'h500 + i);
        end
        step(0);
        chk("t6_no_rd_valid", rd_valid, '0);
        chk("t6_wr_gnt_restart", obs_wg, 2'b01);
        chk("t6_rd_gnt_restart", obs_rg, 2'b01);

        // Random traffic over a small address window to provoke hazards.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!w_pend[i] && $urandom_range(0, 2) == 0) begin
                    w_pend[i] = 1; w_a[i] = AW'($urandom_range(0, 7)); w_d[i] = {$urandom, $urandom};
                end
                if (!r_pend[i] && $urandom_range(0, 2) == 0) begin
                    r_pend[i] = 1; r_a[i] = AW'($urandom_range(0, 7));
                end
            end
            step($urandom_range(0, 99) == 0);
        end
        repeat (12) step(0);
        chk("scoreboard_drained", 64'(q.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
